// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Decodes FPU instructions (op 6'b010001) into a 4-bit control code and
//   sequences multi-cycle operations. A per-class latency counter drives
//   the pipeline stall. The block also produces the start pulse to the
//   datapath, the completion pulse with the code of the finishing op, and
//   a flush abort.
//
//   Optional feature, enabled by defining FPU_PERF_CNT_EN: a free-running
//   stall counter (stall_cycles, PERF_W bits). It counts every clock edge
//   on which fpu_busy is high. Without the macro, the port and the counter
//   do not exist.
//
//   Every *_LAT parameter must lie in 1..2^CNT_W-1.
module fpu_issue_ctrl #(
   parameter int ADD_LAT  = 1,
   parameter int MUL_LAT  = 1,
   parameter int DIV_LAT  = 3,
   parameter int SQRT_LAT = 2,
   parameter int CVT_LAT  = 1,
   parameter int CNT_W    = 4,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic              flush,
   output logic [3:0]        fpucontrol,
   output logic              fpu_start,
   output logic              fpu_busy,
   output logic              result_valid,
   output logic [3:0]        done_ctrl,
   output logic              illegal
`ifdef FPU_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cycles
`endif
);

   localparam logic [5:0] OP_FPU = 6'b010001;

   localparam logic [CNT_W-1:0] ADD_L  = CNT_W'(ADD_LAT);
   localparam logic [CNT_W-1:0] MUL_L  = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_L  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] SQRT_L = CNT_W'(SQRT_LAT);
   localparam logic [CNT_W-1:0] CVT_L  = CNT_W'(CVT_LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       ctrl_reg, ctrl_next;

   logic [3:0]       dec_code;
   logic [CNT_W-1:0] dec_lat;
   logic             dec_supported;
   logic             is_fpu;
   logic             issue;

   // Decode funct into control code and latency class. Non-FPU opcodes and
   // unsupported functs give code 0 and latency 0, so they never issue.
   always_comb begin
      dec_code      = 4'b0000;
      dec_lat       = '0;
      dec_supported = 1'b0;
      if (is_fpu) begin
         dec_supported = 1'b1;
         case (funct)
            6'b000000: begin dec_code = 4'b0000; dec_lat = ADD_L;  end // fadd
            6'b000001: begin dec_code = 4'b0001; dec_lat = ADD_L;  end // fsub
            6'b000010: begin dec_code = 4'b0010; dec_lat = MUL_L;  end // fmul
            6'b000011: begin dec_code = 4'b0011; dec_lat = DIV_L;  end // fdiv
            6'b000100: begin dec_code = 4'b0100; dec_lat = SQRT_L; end // fsqrt
            6'b000101: begin dec_code = 4'b0101; dec_lat = CVT_L;  end // floor
            6'b000110: begin dec_code = 4'b0110; dec_lat = CVT_L;  end // ftoi
            6'b000111: begin dec_code = 4'b0111; dec_lat = CVT_L;  end // itof
            6'b110010: begin dec_code = 4'b1000; dec_lat = '0;     end // feq
            6'b111100: begin dec_code = 4'b1001; dec_lat = '0;     end // fless
            default:   begin dec_code = 4'b0000; dec_lat = '0; dec_supported = 1'b0; end
         endcase
      end
   end

   assign is_fpu  = (op == OP_FPU);
   assign illegal = issue_valid & is_fpu & ~dec_supported;

   // A new op is accepted only when no multi-cycle op is still counting.
   // In the DONE cycle an issue overlaps the previous result pulse.
   assign issue = issue_valid & ~flush & (dec_lat != '0) &
                  ((state_reg == IDLE) || (state_reg == DONE));

   // State, latency counter and latched control code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         ctrl_reg  <= 4'b0000;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ctrl_reg  <= ctrl_next;
      end
   end

   // Next-state logic and all handshake outputs.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      ctrl_next    = ctrl_reg;
      fpu_start    = 1'b0;
      fpu_busy     = 1'b0;
      result_valid = 1'b0;
      done_ctrl    = 4'b0000;
      fpucontrol   = issue_valid ? dec_code : 4'b0000;

      case (state_reg)
         BUSY: begin
            // The stalled instruction is held upstream, so decode is ignored.
            fpu_busy   = 1'b1;
            fpucontrol = ctrl_reg;
            if (flush) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - 1'b1;
               if (cnt_reg == 1) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (flush) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               result_valid = 1'b1;
               done_ctrl    = ctrl_reg;
               state_next   = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // The issue path overrides the IDLE/DONE defaults above.
      if (issue) begin
         fpu_start  = 1'b1;
         fpu_busy   = 1'b1;
         fpucontrol = dec_code;
         ctrl_next  = dec_code;
         if (dec_lat == 1) begin
            state_next = DONE;
            cnt_next   = '0;
         end else begin
            state_next = BUSY;
            cnt_next   = dec_lat - 1'b1;
         end
      end
   end

`ifdef FPU_PERF_CNT_EN
   logic [PERF_W-1:0] stall_reg;

   // Count every edge that sees a stall; wraps naturally and ignores flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_reg <= '0;
      end else if (fpu_busy) begin
         stall_reg <= stall_reg + 1'b1;
      end
   end

   assign stall_cycles = stall_reg;
`endif

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Parametrised successor of the FPU decoder. Decodes FPU instructions (op 6'b010001) into a 4-bit FPU control code.
- Sequences multi-cycle FPU operations: per-class latency counter, pipeline stall, start pulse, completion pulse and flush abort.
- Sits between decode and the FPU datapath. Replaces fixed 2-bit stall codes with a real counter and handshake.

Parameters:
- ADD_LAT, 1, stall cycles for fadd/fsub
- MUL_LAT, 1, stall cycles for fmul
- DIV_LAT, 3, stall cycles for fdiv
- SQRT_LAT, 2, stall cycles for fsqrt
- CVT_LAT, 1, stall cycles for floor/ftoi/itof
- CNT_W, 4, latency counter width; every *_LAT must lie in 1..2^CNT_W-1
- PERF_W, 32, width of the stall performance counter (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction in decode is valid and may issue
- op  in  6  opcode field
- funct  in  6  function field
- flush  in  1  synchronous abort of the in-flight and issuing FPU op
- fpucontrol  out  4  control code to FPU datapath
- fpu_start  out  1  one-cycle start pulse to FPU
- fpu_busy  out  1  pipeline stall request
- result_valid  out  1  one-cycle pulse: multi-cycle result ready
- done_ctrl  out  4  control code of the completing op, valid with result_valid
- illegal  out  1  FPU opcode with unsupported funct
- stall_cycles  out  PERF_W  stall counter (FPU_PERF_CNT_EN only)

Behaviour:
- Decode: funct 000000..000111 -> codes 0000..0111 (fadd, fsub, fmul, fdiv, fsqrt, floor, ftoi, itof). 110010 -> 1000 (feq). 111100 -> 1001 (fless).
- If op != 010001: code 0000, latency 0. Unsupported funct: code 0000 (never X), latency 0.
- illegal = issue_valid & op==010001 & unsupported funct. It is combinational.
- Latency classes: fadd/fsub ADD_LAT, fmul MUL_LAT, fdiv DIV_LAT, fsqrt SQRT_LAT, floor/ftoi/itof CVT_LAT, feq/fless 0.
- issue = issue_valid & ~flush & decoded latency L>0 & state in {IDLE, DONE}.
- States: IDLE, BUSY, DONE. Reset -> IDLE, counter 0, latched code 0, all outputs 0.
- Issue cycle T (combinational outputs):
  - fpu_start=1, fpu_busy=1, fpucontrol = decoded code.
  - Code latched into ctrl_q.
  - If L==1: next state DONE. Else: cnt <= L-1 and next state BUSY.
- BUSY:
  - fpu_busy=1, fpucontrol=ctrl_q, cnt decrements each cycle.
  - When cnt==1: next state DONE.
  - Net effect: fpu_busy is high exactly on cycles T..T+L-1.
- DONE (cycle T+L):
  - result_valid=1, done_ctrl=ctrl_q, fpu_busy=0.
  - A new issue in the same cycle is accepted. It behaves as the issue cycle above, overlapping with result_valid.
  - Without a new issue, next state is IDLE.
- Outside BUSY, fpucontrol is the combinational decode of the current op/funct, gated to 0 when issue_valid=0.
- Latency-0 ops (feq/fless): fpucontrol only. No start, busy or result_valid.
- flush:
  - In BUSY or DONE: next state IDLE, cnt 0. No further result_valid; result_valid is suppressed in a DONE cycle if flush is high.
  - In the issue cycle: issue is suppressed (no fpu_start, fpu_busy=0).
- issue_valid is ignored while BUSY. The stalled instruction is held upstream.
- Asynchronous reset mid-operation: immediately IDLE, fpu_busy=0, no result_valid afterwards.
- done_ctrl is 0 whenever result_valid=0.

Optional Feature:
- Macro FPU_PERF_CNT_EN.
- Defined:
  - stall_cycles increments by 1 on every clk edge where fpu_busy=1, and wraps at 2^PERF_W.
  - Reset clears it to 0. flush does not clear it.
- Undefined: the stall_cycles port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then fdiv (op 010001, funct 000011, defaults) issued at cycle 0:
  - fpu_start=1 at cycle 0 only.
  - fpu_busy=1 at cycles 0,1,2.
  - result_valid=1 and done_ctrl=0011 at cycle 3.
- fadd then immediate fmul issued in fadd's DONE cycle:
  - result_valid (done_ctrl 0000) and fpu_start (fpucontrol 0010) both high in the same cycle.
  - fmul result_valid one cycle later.
- feq (funct 110010): fpucontrol=1000. fpu_start, fpu_busy and result_valid stay 0.
- Illegal funct 001000 with op 010001: illegal=1, fpucontrol=0000, no stall. Non-FPU op 000000: illegal=0, fpucontrol=0000.
- fsqrt issued, flush at cycle 1: IDLE at cycle 2, no result_valid. Async reset asserted mid-fdiv: fpu_busy drops without waiting for clk.
- FPU_PERF_CNT_EN defined, run fdiv + fsqrt + fadd: stall_cycles=6. Overflow check with PERF_W=3: wraps 7 -> 0.
